imem_arbiter: RTL
=================

// Module: imem_arbiter
// PURPOSE
//   Shares the single combinational instruction-ROM read port between two requesters:
//   the fetch stage (port F) and the read-only data-load path (port L), for constants in ROM.
//   Grants at most one request per cycle, drives the ROM address and registers the word.
//   Returns the word to the granted port one cycle later. Load has priority, with a
//   starvation guard so that fetch always makes progress.
// PARAMETERS
//   ROM          15872  ROM depth in 32-bit words; word addresses >= ROM are out of range
//   MAX_STREAK   4      max consecutive L grants while F is waiting (1..15)
// PORTS
//   clk            in   1   rising-edge clock
//   reset          in   1   synchronous, active-high reset
//   f_req_valid    in   1   fetch request valid
//   f_req_ready    out  1   fetch request accepted this cycle (combinational grant)
//   f_req_addr     in   14  fetch word address
//   f_flush        in   1   redirect: squash any fetch response due next cycle
//   f_resp_valid   out  1   fetch response valid (single-cycle pulse)
//   f_resp_data    out  32  fetch response word
//   f_resp_err     out  1   fetch address was out of range
//   l_req_valid    in   1   load request valid
//   l_req_ready    out  1   load request accepted this cycle
//   l_req_addr     in   14  load word address
//   l_resp_valid   out  1   load response valid (single-cycle pulse)
//   l_resp_data    out  32  load response word
//   l_resp_err     out  1   load address was out of range
//   imem_addr      out  14  to ROM address
//   imem_data      in   32  from ROM, combinational on imem_addr
// BEHAVIOUR
//   - Clock domain and reset: one clock (clk); reset is synchronous and active-high (reset).
//   - Reset: all resp_valid/err = 0, resp_data = 0, streak = 0, owner = NONE; ready outputs
//     are 0 while reset is high.
//   - Handshake: a request transfers when valid && ready in the same cycle. At most one ready
//     is high per cycle. A requester holds valid/addr stable until ready.
//   - Arbitration (combinational each cycle):
//     only F valid -> grant F; only L valid -> grant L;
//     both valid -> grant L unless streak == MAX_STREAK, in which case grant F.
//   - Streak counter (4-bit): on an L grant with F valid, streak += 1 (saturating at MAX_STREAK).
//     On an F grant, or when F is not valid, streak = 0.
//   - imem_addr = granted port's address. With no grant, hold the last driven address so the
//     ROM does not toggle.
//   - Owner register: NONE / F / L, set to the granted port at the clock edge, NONE if no grant.
//   - Latency: exactly 1 cycle. In cycle N+1 after a grant in cycle N, the owner's resp_valid = 1.
//     resp_data = imem_data registered at the edge ending cycle N.
//     Full throughput: a grant is possible every cycle, back-to-back.
//   - Range check: addr >= ROM -> resp_err = 1, resp_data = 0, resp_valid still pulses.
//     The ROM index is never used out of range; imem_addr is forced to 0 for that access.
//   - f_flush in cycle N: an F request granted in cycle N-1 yields no f_resp_valid in cycle N.
//     An F request presented in cycle N is not granted (f_req_ready = 0) while f_flush = 1.
//     L is unaffected.
//   - Response data is held in the registers after the pulse; only resp_valid qualifies it.
//   - Reset mid-operation: an in-flight response is dropped (no resp_valid in the cycle after
//     reset), and streak is cleared.
// TESTING
//   1. Reset, then F request addr 0x0005 (rom[5] = 0xDEADBEEF): f_req_ready = 1 same cycle;
//      next cycle f_resp_valid = 1, data 0xDEADBEEF, err = 0.
//   2. F and L both held valid 10 cycles, MAX_STREAK = 4: grant order L,L,L,L,F,L,L,L,L,F.
//      Responses match each port's address.
//   3. L request addr 15872: l_resp_valid = 1, l_resp_err = 1, data 0. Then addr 15871 with
//      rom[15871] = 0x12345678: err = 0, data 0x12345678.
//   4. F granted at 0x0010, f_flush next cycle with F valid at 0x0020: no f_resp_valid that
//      cycle and f_req_ready = 0. The following cycle, F at 0x0020 is granted normally.
//   5. Back-to-back F requests 0x0000..0x0007 with L idle: eight consecutive f_resp_valid
//      pulses, data = rom[0..7] in order, no bubbles.
//   6. Assert reset the cycle after an L grant: no l_resp_valid follows, all outputs at reset
//      values, streak = 0.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Request/response bundle between the fetch and load requesters, the shared ROM port and
// the arbiter. The arbiter uses the slave modport; the requester/ROM side uses master.
interface imem_arbiter_if;
    logic        f_req_valid;
    logic        f_req_ready;
    logic [13:0] f_req_addr;
    logic        f_flush;
    logic        f_resp_valid;
    logic [31:0] f_resp_data;
    logic        f_resp_err;

    logic        l_req_valid;
    logic        l_req_ready;
    logic [13:0] l_req_addr;
    logic        l_resp_valid;
    logic [31:0] l_resp_data;
    logic        l_resp_err;

    logic [13:0] imem_addr;
    logic [31:0] imem_data;

    modport slave (
        input  f_req_valid, f_req_addr, f_flush, l_req_valid, l_req_addr, imem_data,
        output f_req_ready, f_resp_valid, f_resp_data, f_resp_err,
               l_req_ready, l_resp_valid, l_resp_data, l_resp_err, imem_addr
    );

    modport master (
        output f_req_valid, f_req_addr, f_flush, l_req_valid, l_req_addr, imem_data,
        input  f_req_ready, f_resp_valid, f_resp_data, f_resp_err,
               l_req_ready, l_resp_valid, l_resp_data, l_resp_err, imem_addr
    );
endinterface

// File: rtl/imem_arbiter.sv
// Arbitrates the single combinational ROM read port between fetch (F) and load (L).
// Load wins ties, but a streak counter forces an F grant after MAX_STREAK L grants.
module imem_arbiter #(
    parameter int unsigned ROM        = 15872,
    parameter int unsigned MAX_STREAK = 4
) (
    input logic           clk,
    input logic           reset,
    imem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {OwnNone, OwnF, OwnL} owner_e;

    localparam logic [3:0] StreakMax = 4'(MAX_STREAK);

    owner_e      owner_q, owner_d;
    logic [3:0]  streak_q, streak_d;
    logic [13:0] last_addr_q, sel_addr, drv_addr;
    logic [31:0] f_data_q, l_data_q;
    logic        f_err_q, l_err_q;
    logic        f_elig, l_elig, grant_f, grant_l, in_range;

    // A flushing fetch is not eligible; ready outputs stay low throughout reset.
    always_comb begin
        f_elig   = bus.f_req_valid && !bus.f_flush && !reset;
        l_elig   = bus.l_req_valid && !reset;
        grant_l  = l_elig && !(f_elig && (streak_q == StreakMax));
        grant_f  = f_elig && !grant_l;
        sel_addr = grant_l ? bus.l_req_addr : bus.f_req_addr;
        in_range = 32'(sel_addr) < ROM;
        drv_addr = (grant_f || grant_l) ? (in_range ? sel_addr : '0) : last_addr_q;
    end

    always_comb begin
        streak_d = streak_q;
        if (grant_f || !bus.f_req_valid) begin
            streak_d = '0;
        end else if (grant_l && (streak_q < StreakMax)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // Owner state register
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OwnNone;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        owner_d = OwnNone;
        if (grant_l) begin
            owner_d = OwnL;
        end else if (grant_f) begin
            owner_d = OwnF;
        end
    end

    always_comb begin
        bus.f_req_ready  = grant_f;
        bus.l_req_ready  = grant_l;
        bus.imem_addr    = drv_addr;
        bus.f_resp_valid = (owner_q == OwnF) && !bus.f_flush && !reset;
        bus.l_resp_valid = (owner_q == OwnL) && !reset;
        bus.f_resp_data  = f_data_q;
        bus.f_resp_err   = f_err_q;
        bus.l_resp_data  = l_data_q;
        bus.l_resp_err   = l_err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q    <= '0;
            last_addr_q <= '0;
            f_data_q    <= '0;
            f_err_q     <= 1'b0;
            l_data_q    <= '0;
            l_err_q     <= 1'b0;
        end else begin
            streak_q    <= streak_d;
            last_addr_q <= drv_addr;
            if (grant_f) begin
                f_data_q <= in_range ? bus.imem_data : '0;
                f_err_q  <= !in_range;
            end
            if (grant_l) begin
                l_data_q <= in_range ? bus.imem_data : '0;
                l_err_q  <= !in_range;
            end
        end
    end
endmodule
